// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the instruction-memory boot loader.
package imem_loader_pkg;

  // Loader FSM states; CHK is reachable only in the checksum build.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_HI = 3'd1,
    LEN_LO = 3'd2,
    DATA   = 3'd3,
    WRITE  = 3'd4,
    CHK    = 3'd5,
    DONE   = 3'd6,
    ERR    = 3'd7
  } state_t;

  localparam int WORD_BYTES = 4;
  localparam int LEN_BYTES  = 2;
  localparam int LEN_W      = 8 * LEN_BYTES;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte packer: shifts bytes into a 32-bit word, flags the 4th byte.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        shift_en,
  input  logic [7:0]  din,
  output logic [31:0] word,
  output logic        word_full
);

  logic [1:0] cnt;

  // Shift register and byte counter; clear drops any partially packed word.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= 2'd0;
      word <= 32'd0;
    end else if (clr) begin
      cnt <= 2'd0;
    end else if (shift_en) begin
      word <= {word[23:0], din};
      cnt  <= cnt + 2'd1;
    end
  end

  // Pulses in the cycle the last byte of a word is being accepted.
  assign word_full = shift_en && (cnt == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// Boot-time instruction memory loader: receives a length-prefixed big-endian
// byte stream, writes 32-bit words from address 0 and holds the core in reset
// until the whole image is in place.
// Optional build macro IMEM_LOADER_CHECKSUM_EN adds a trailing XOR checksum
// byte (CHK state); without it the frame ends after the payload.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic              im_we,
  output logic [ADDR_W-1:0] im_addr,
  output logic [31:0]       im_wdata,
  output logic              cpu_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam logic [LEN_W:0] MAX_LEN = (LEN_W + 1)'(MEM_DEPTH);

  state_t             state, state_n;
  logic [7:0]         len_hi;
  logic [LEN_W-1:0]   len_q;
  logic [LEN_W-1:0]   len_n;
  logic [LEN_W-1:0]   idx;
  logic               accept;
  logic               start_go;
  logic               shift_en;
  logic               word_full;
  logic               last_word;

  assign accept    = rx_valid && rx_ready;
  assign start_go  = start && ((state == IDLE) || (state == DONE) || (state == ERR));
  assign shift_en  = accept && (state == DATA);
  assign len_n     = {len_hi, rx_data};
  assign last_word = (idx == (len_q - LEN_W'(1)));

  imem_loader_byte_packer u_byte_packer (
    .clk       (clk),
    .rst       (rst),
    .clr       (start_go),
    .shift_en  (shift_en),
    .din       (rx_data),
    .word      (im_wdata),
    .word_full (word_full)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum;

  // Running XOR over payload bytes only; restarted with every load.
  always_ff @(posedge clk) begin
    if (rst || start_go) begin
      csum <= 8'd0;
    end else if (shift_en) begin
      csum <= csum ^ rx_data;
    end
  end
`endif

  // Next-state decode for the frame sequencer.
  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (start) state_n = LEN_HI;
      LEN_HI: if (accept) state_n = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if (len_n == '0)                   state_n = DONE;
          else if ({1'b0, len_n} > MAX_LEN)  state_n = ERR;
          else                               state_n = DATA;
        end
      end
      DATA:   if (word_full) state_n = WRITE;
      WRITE: begin
        if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_n = CHK;
`else
          state_n = DONE;
`endif
        end else begin
          state_n = DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK:    if (accept) state_n = (csum == rx_data) ? DONE : ERR;
`endif
      DONE:   if (start) state_n = LEN_HI;
      ERR:    if (start) state_n = LEN_HI;
      default: state_n = IDLE;
    endcase
  end

  // State register with outputs registered from the next state so they line
  // up with the state they describe.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rx_ready <= 1'b0;
      im_we    <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      cpu_rst  <= 1'b1;
      im_addr  <= '0;
      idx      <= '0;
    end else begin
      state    <= state_n;
      rx_ready <= (state_n == LEN_HI) || (state_n == LEN_LO) ||
                  (state_n == DATA)   || (state_n == CHK);
      busy     <= (state_n == LEN_HI) || (state_n == LEN_LO) ||
                  (state_n == DATA)   || (state_n == WRITE)  || (state_n == CHK);
      im_we    <= (state_n == WRITE);
      done     <= (state_n == DONE);
      err      <= (state_n == ERR);
      cpu_rst  <= (state_n != DONE);
      if (start_go || ((state == LEN_LO) && accept)) begin
        im_addr <= '0;
        idx     <= '0;
      end else if ((state == WRITE) && !last_word) begin
        im_addr <= im_addr + ADDR_W'(1);
        idx     <= idx + LEN_W'(1);
      end
    end
  end

  // Length bytes are captured as they arrive; no reset needed on this data.
  always_ff @(posedge clk) begin
    if ((state == LEN_HI) && accept) len_hi <= rx_data;
    if ((state == LEN_LO) && accept) len_q  <= len_n;
  end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write scoreboard.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic        im_we;
  logic [7:0]  im_addr;
  logic [31:0] im_wdata;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } exp_t;

  exp_t       sb[$];
  int         checks   = 0;
  int         failures = 0;
  int         wr_count = 0;
  logic [7:0] exp_csum;
  logic       toggle = 1'b0;

  always #5 clk = ~clk;

  imem_loader #(.ADDR_W(8), .MEM_DEPTH(256)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .rx_valid (rx_valid),
    .rx_data  (rx_data),
    .rx_ready (rx_ready),
    .im_we    (im_we),
    .im_addr  (im_addr),
    .im_wdata (im_wdata),
    .cpu_rst  (cpu_rst),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  // Write monitor: every im_we pulse must match the head of the scoreboard.
  always @(negedge clk) begin
    if (im_we) begin
      exp_t e;
      wr_count++;
      checks++;
      assert (sb.size() > 0) else begin
        failures++;
        $error("FAIL sb_unexpected_write observed addr=%h data=%h expected none", im_addr, im_wdata);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        assert (im_addr === e.addr) else begin
          failures++;
          $error("FAIL wr_addr observed=%h expected=%h", im_addr, e.addr);
        end
        checks++;
        assert (im_wdata === e.data) else begin
          failures++;
          $error("FAIL wr_data observed=%h expected=%h", im_wdata, e.data);
        end
      end
      checks++;
      assert (rx_ready === 1'b0) else begin
        failures++;
        $error("FAIL ready_in_write observed=%b expected=0", rx_ready);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int t = 0;
    rx_valid = 1'b1;
    rx_data  = b;
    while (!rx_ready && t < 50) begin
      @(posedge clk);
      #1 t++;
    end
    checks++;
    assert (rx_ready === 1'b1) else begin
      failures++;
      $error("FAIL byte_timeout observed=%b expected=1", rx_ready);
    end
    if (rx_ready) begin
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    if (toggle) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_len(input logic [15:0] n);
    logic [15:0] v;
    v = n;
    exp_csum = 8'h00;
    send_byte(v[15:8]);
    send_byte(v[7:0]);
  endtask

  task automatic send_word(input logic [31:0] w, input logic [7:0] a);
    exp_t e;
    e.addr = a;
    e.data = w;
    sb.push_back(e);
    for (int k = 3; k >= 0; k--) begin
      exp_csum = exp_csum ^ w[8*k +: 8];
      send_byte(w[8*k +: 8]);
    end
  endtask

  task automatic finish_frame();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(exp_csum);
`endif
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wr0;
    rst = 1'b1; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    do_reset();

    chk("rst_rx_ready", 32'(rx_ready), 32'd0);
    chk("rst_im_we", 32'(im_we), 32'd0);
    chk("rst_im_addr", 32'(im_addr), 32'd0);
    chk("rst_im_wdata", im_wdata, 32'd0);
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);

    // N=2, valid held high
    pulse_start();
    chk("lenhi_ready", 32'(rx_ready), 32'd1);
    chk("lenhi_busy", 32'(busy), 32'd1);
    send_len(16'd2);
    send_word(32'h010A4820, 8'd0);
    send_word(32'h01095022, 8'd1);
    finish_frame();
    chk("n2_done", 32'(done), 32'd1);
    chk("n2_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("n2_busy", 32'(busy), 32'd0);
    chk("n2_writes", 32'(wr_count), 32'd2);

    // Same frame, valid toggled every other cycle
    toggle = 1'b1;
    pulse_start();
    send_len(16'd2);
    send_word(32'h010A4820, 8'd0);
    send_word(32'h01095022, 8'd1);
    finish_frame();
    toggle = 1'b0;
    chk("tog_done", 32'(done), 32'd1);
    chk("tog_writes", 32'(wr_count), 32'd4);

    // N=0 -> DONE with no writes
    wr0 = wr_count;
    pulse_start();
    send_len(16'd0);
    chk("n0_done", 32'(done), 32'd1);
    chk("n0_cpu_rst", 32'(cpu_rst), 32'd0);
    chk("n0_ready", 32'(rx_ready), 32'd0);

    // N=257 -> ERR with no writes
    pulse_start();
    send_len(16'h0101);
    repeat (3) @(posedge clk);
    #1;
    chk("n257_err", 32'(err), 32'd1);
    chk("n257_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("n257_done", 32'(done), 32'd0);
    chk("n257_busy", 32'(busy), 32'd0);
    chk("n0_n257_writes", 32'(wr_count - wr0), 32'd0);

    // Leaving ERR clears err
    pulse_start();
    chk("err_restart_err", 32'(err), 32'd0);
    chk("err_restart_busy", 32'(busy), 32'd1);

    // Reset after 6 payload bytes
    send_len(16'd2);
    send_word(32'hCAFEF00D, 8'd0);
    send_byte(8'h11);
    send_byte(8'h22);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("midrst_ready", 32'(rx_ready), 32'd0);
    chk("midrst_im_we", 32'(im_we), 32'd0);
    chk("midrst_im_addr", 32'(im_addr), 32'd0);
    chk("midrst_im_wdata", im_wdata, 32'd0);
    chk("midrst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    chk("midrst_err", 32'(err), 32'd0);
    chk("midrst_sb_empty", 32'(sb.size()), 32'd0);
    pulse_start();
    send_len(16'd1);
    send_word(32'hAABBCCDD, 8'd0);
    finish_frame();
    chk("after_rst_done", 32'(done), 32'd1);

    // start during DATA is ignored
    pulse_start();
    send_len(16'd1);
    send_byte(8'h12);
    send_byte(8'h34);
    exp_csum = 8'h12 ^ 8'h34;
    pulse_start();
    chk("ign_start_busy", 32'(busy), 32'd1);
    chk("ign_start_ready", 32'(rx_ready), 32'd1);
    begin
      exp_t e;
      e.addr = 8'd0;
      e.data = 32'h12345678;
      sb.push_back(e);
    end
    exp_csum = exp_csum ^ 8'h56 ^ 8'h78;
    send_byte(8'h56);
    send_byte(8'h78);
    finish_frame();
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_cpu_rst", 32'(cpu_rst), 32'd0);

    // Restart from DONE reasserts cpu_rst in the same cycle
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    chk("reload_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("reload_done", 32'(done), 32'd0);
    chk("reload_addr", 32'(im_addr), 32'd0);

    // Full depth N=256, addresses 0..255 without wrap
    wr0 = wr_count;
    send_len(16'd256);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send_word({b, ~b, b ^ 8'h5A, 8'hC3}, b);
    end
    finish_frame();
    chk("full_done", 32'(done), 32'd1);
    chk("full_writes", 32'(wr_count - wr0), 32'd256);

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_start();
    send_len(16'd1);
    send_word(32'hDEADBEEF, 8'd0);
    chk("csum_model", 32'(exp_csum), 32'h22);
    send_byte(8'h22);
    @(posedge clk);
    #1;
    chk("csum_ok_done", 32'(done), 32'd1);
    chk("csum_ok_err", 32'(err), 32'd0);
    pulse_start();
    send_len(16'd1);
    send_word(32'hDEADBEEF, 8'd0);
    send_byte(8'h23);
    @(posedge clk);
    #1;
    chk("csum_bad_err", 32'(err), 32'd1);
    chk("csum_bad_done", 32'(done), 32'd0);
    chk("csum_bad_cpu_rst", 32'(cpu_rst), 32'd1);
`endif

    repeat (2) @(posedge clk);
    #1;
    chk("sb_drained", 32'(sb.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
